// File: rtl/tluh_pkg.sv
// rtl/tluh_pkg.sv - shared TL-UH SRAM types, limits and parity helper
package tluh_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } sram_mem_state_e;

  localparam int SramMaxReadLat = 4;

  // Even parity: the stored bit makes the byte plus parity carry an even count of ones.
  function automatic logic byte_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/tluh_sram_rd_pipe.sv
// rtl/tluh_sram_rd_pipe.sv - ReadLat-deep valid/data/error shift pipe, async clear
module tluh_sram_rd_pipe
  import tluh_pkg::*;
#(
  parameter int Dw      = 32,
  parameter int ReadLat = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          valid_i,
  input  logic [Dw-1:0] data_i,
  input  logic          err_i,
  output logic          valid_o,
  output logic [Dw-1:0] data_o,
  output logic          err_o
);

  localparam int Lat = (ReadLat < 1) ? 1 :
                       (ReadLat > SramMaxReadLat) ? SramMaxReadLat : ReadLat;

  logic [Lat-1:0] vld_q;
  logic [Lat-1:0] err_q;
  logic [Dw-1:0]  dat_q [Lat];

  // Data stages only load behind a valid beat so the output holds between reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < Lat; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= valid_i;
      if (valid_i) begin
        dat_q[0] <= data_i;
        err_q[0] <= err_i;
      end
      for (int i = 1; i < Lat; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
          err_q[i] <= err_q[i-1];
        end
      end
    end
  end

  assign valid_o = vld_q[Lat-1];
  assign data_o  = dat_q[Lat-1];
  assign err_o   = err_q[Lat-1] & vld_q[Lat-1];

endmodule

// File: rtl/tluh_sram_mem.sv
// rtl/tluh_sram_mem.sv - register-array SRAM with zero-init sequencer and fixed read latency
// Optional per-byte parity and error injection under TLUH_SRAM_MEM_PARITY_EN.
module tluh_sram_mem
  import tluh_pkg::*;
#(
  parameter int SramDw  = 32,
  parameter int SramAw  = 12,
  parameter int Depth   = 4096,
  parameter int ReadLat = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic              we_i,
  input  logic [SramAw-1:0] addr_i,
  input  logic [SramDw-1:0] wdata_i,
  input  logic [SramDw-1:0] wmask_i,
`ifdef TLUH_SRAM_MEM_PARITY_EN
  input  logic              err_inj_i,
`endif
  output logic [SramDw-1:0] rdata_o,
  output logic              rvalid_o,
  output logic [1:0]        rerror_o,
  output logic              init_done_o
);

  localparam int              IdxW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int              Nb      = SramDw / 8;
  localparam logic [SramAw:0] DepthW  = (SramAw + 1)'(Depth);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Depth - 1);

  sram_mem_state_e   state_q, state_d;
  logic [IdxW-1:0]   cnt_q, cnt_d;
  logic [SramDw-1:0] mem_q [Depth];

  logic              accept, wr_acc, rd_acc, addr_ok, rd_err, pipe_err;
  logic [IdxW-1:0]   idx;
  logic [SramDw-1:0] cur_word, merged, rd_data;

  assign gnt_o       = (state_q == READY);
  assign init_done_o = (state_q == READY);
  assign accept      = req_i & gnt_o;
  assign wr_acc      = accept & we_i;
  assign rd_acc      = accept & ~we_i;
  assign addr_ok     = ({1'b0, addr_i} < DepthW);
  assign idx         = addr_i[IdxW-1:0];
  assign cur_word    = mem_q[idx];
  assign merged      = (cur_word & ~wmask_i) | (wdata_i & wmask_i);
  assign rd_data     = addr_ok ? cur_word : '1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LastIdx) state_d = READY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The array itself is not reset; the INIT sweep clears it after every reset.
  always_ff @(posedge clk_i) begin
    if (state_q == INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_acc && addr_ok) begin
      mem_q[idx] <= merged;
    end
  end

`ifdef TLUH_SRAM_MEM_PARITY_EN
  logic [Nb-1:0] par_q [Depth];
  logic [Nb-1:0] cur_par, wr_par;

  always_comb begin
    cur_par = par_q[idx];
    rd_err  = 1'b0;
    wr_par  = '0;
    for (int b = 0; b < Nb; b++) begin
      if (byte_parity(cur_word[8*b +: 8]) != cur_par[b]) rd_err = 1'b1;
      wr_par[b] = (|wmask_i[8*b +: 8]) ? byte_parity(merged[8*b +: 8]) : cur_par[b];
    end
    wr_par = wr_par ^ {Nb{err_inj_i}};
    rd_err = rd_err & addr_ok;
  end

  always_ff @(posedge clk_i) begin
    if (state_q == INIT) begin
      par_q[cnt_q] <= '0;
    end else if (wr_acc && addr_ok) begin
      par_q[idx] <= wr_par;
    end
  end
`else
  assign rd_err = 1'b0;
`endif

  tluh_sram_rd_pipe #(
    .Dw      (SramDw),
    .ReadLat (ReadLat)
  ) u_rd_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (rd_acc),
    .data_i  (rd_data),
    .err_i   (rd_err),
    .valid_o (rvalid_o),
    .data_o  (rdata_o),
    .err_o   (pipe_err)
  );

  assign rerror_o = {pipe_err, 1'b0};

endmodule

// File: tb/tb_tluh_sram_mem.sv
// tb/tb_tluh_sram_mem.sv - directed vector bench for tluh_sram_mem at ReadLat 1 and 3
module tb_tluh_sram_mem;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i, err_inj_i;
  logic [11:0] addr_i;
  logic [31:0] wdata_i, wmask_i;

  logic        g1, v1, d1, g3, v3, d3;
  logic [31:0] rd1, rd3;
  logic [1:0]  re1, re3;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic        req;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] wmask;
    logic [31:0] exp;
    logic [1:0]  eerr;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [1:0]  err;
  } exp_t;

  vec_t vecs [18];
  exp_t q1 [$];
  exp_t q3 [$];

  always #5 clk = ~clk;

  tluh_sram_mem #(.SramDw(32), .SramAw(12), .Depth(16), .ReadLat(1)) u_lat1 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(g1), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .wmask_i(wmask_i),
`ifdef TLUH_SRAM_MEM_PARITY_EN
    .err_inj_i(err_inj_i),
`endif
    .rdata_o(rd1), .rvalid_o(v1), .rerror_o(re1), .init_done_o(d1)
  );

  tluh_sram_mem #(.SramDw(32), .SramAw(12), .Depth(16), .ReadLat(3)) u_lat3 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(g3), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .wmask_i(wmask_i),
`ifdef TLUH_SRAM_MEM_PARITY_EN
    .err_inj_i(err_inj_i),
`endif
    .rdata_o(rd3), .rvalid_o(v3), .rerror_o(re3), .init_done_o(d3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon();
    if (q1.size() > 0 && q1[0].due == cyc) begin
      chk("lat1_rvalid", {31'd0, v1}, 32'd1);
      chk("lat1_rdata", rd1, q1[0].data);
      chk("lat1_rerror", {30'd0, re1}, {30'd0, q1[0].err});
      void'(q1.pop_front());
    end else begin
      chk("lat1_idle", {29'd0, v1, re1}, 32'd0);
    end
    if (q3.size() > 0 && q3[0].due == cyc) begin
      chk("lat3_rvalid", {31'd0, v3}, 32'd1);
      chk("lat3_rdata", rd3, q3[0].data);
      chk("lat3_rerror", {30'd0, re3}, {30'd0, q3[0].err});
      void'(q3.pop_front());
    end else begin
      chk("lat3_idle", {29'd0, v3, re3}, 32'd0);
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic apply(input logic req, input logic we, input logic [11:0] addr,
                       input logic [31:0] wd, input logic [31:0] wm, input logic inj,
                       input logic [31:0] exp, input logic [1:0] eerr);
    req_i     = req;
    we_i      = we;
    addr_i    = addr;
    wdata_i   = wd;
    wmask_i   = wm;
    err_inj_i = inj;
    if (req && !we) begin
      q1.push_back('{due: cyc + 1, data: exp, err: eerr});
      q3.push_back('{due: cyc + 3, data: exp, err: eerr});
    end
    step();
  endtask

  task automatic drain();
    req_i     = 1'b0;
    we_i      = 1'b0;
    err_inj_i = 1'b0;
    repeat (5) step();
    chk("drain_lat1", q1.size(), 32'd0);
    chk("drain_lat3", q3.size(), 32'd0);
  endtask

  task automatic do_init();
    int n1 = 0;
    int n3 = 0;
    for (int i = 0; i < 40; i++) begin
      if (g1 && g3) break;
      if (!g1) n1++;
      if (!g3) n3++;
      step();
    end
    chk("init_cycles_lat1", n1, 32'd16);
    chk("init_cycles_lat3", n3, 32'd16);
    chk("gnt_lat1", {31'd0, g1}, 32'd1);
    chk("init_done_lat1", {31'd0, d1}, 32'd1);
    chk("gnt_lat3", {31'd0, g3}, 32'd1);
    chk("init_done_lat3", {31'd0, d3}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 12'd5,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2'b00};
    vecs[1]  = '{1'b1, 1'b1, 12'd0,  32'h0000_0037, 32'hFFFF_FFFF, 32'h0000_0000, 2'b00};
    vecs[2]  = '{1'b1, 1'b0, 12'd0,  32'h0000_0000, 32'h0000_0000, 32'h0000_0037, 2'b00};
    vecs[3]  = '{1'b1, 1'b1, 12'd3,  32'hAABB_CCDD, 32'hFFFF_FFFF, 32'h0000_0000, 2'b00};
    vecs[4]  = '{1'b1, 1'b1, 12'd3,  32'h1122_3344, 32'h0000_FFFF, 32'h0000_0000, 2'b00};
    vecs[5]  = '{1'b1, 1'b0, 12'd3,  32'h0000_0000, 32'h0000_0000, 32'hAABB_3344, 2'b00};
    vecs[6]  = '{1'b1, 1'b1, 12'd1,  32'h0101_0101, 32'hFFFF_FFFF, 32'h0000_0000, 2'b00};
    vecs[7]  = '{1'b1, 1'b1, 12'd2,  32'h0202_0202, 32'hFFFF_FFFF, 32'h0000_0000, 2'b00};
    vecs[8]  = '{1'b1, 1'b0, 12'd1,  32'h0000_0000, 32'h0000_0000, 32'h0101_0101, 2'b00};
    vecs[9]  = '{1'b1, 1'b0, 12'd2,  32'h0000_0000, 32'h0000_0000, 32'h0202_0202, 2'b00};
    vecs[10] = '{1'b1, 1'b0, 12'd3,  32'h0000_0000, 32'h0000_0000, 32'hAABB_3344, 2'b00};
    vecs[11] = '{1'b1, 1'b1, 12'd20, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0000_0000, 2'b00};
    vecs[12] = '{1'b1, 1'b0, 12'd20, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 2'b00};
    vecs[13] = '{1'b1, 1'b0, 12'd4,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2'b00};
    vecs[14] = '{1'b0, 1'b0, 12'd0,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2'b00};
    vecs[15] = '{1'b1, 1'b1, 12'd7,  32'h1234_5678, 32'hFF00_FF00, 32'h0000_0000, 2'b00};
    vecs[16] = '{1'b1, 1'b1, 12'd0,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 2'b00};
    vecs[17] = '{1'b1, 1'b0, 12'd7,  32'h0000_0000, 32'h0000_0000, 32'h1200_5600, 2'b00};

    rst_ni    = 1'b0;
    req_i     = 1'b0;
    we_i      = 1'b0;
    err_inj_i = 1'b0;
    addr_i    = '0;
    wdata_i   = '0;
    wmask_i   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt_lat1", {31'd0, g1}, 32'd0);
    chk("rst_done_lat1", {31'd0, d1}, 32'd0);
    chk("rst_rvalid_lat1", {31'd0, v1}, 32'd0);
    chk("rst_rdata_lat1", rd1, 32'd0);
    chk("rst_rerror_lat1", {30'd0, re1}, 32'd0);
    chk("rst_gnt_lat3", {31'd0, g3}, 32'd0);
    chk("rst_done_lat3", {31'd0, d3}, 32'd0);
    chk("rst_rvalid_lat3", {31'd0, v3}, 32'd0);
    chk("rst_rdata_lat3", rd3, 32'd0);
    chk("rst_rerror_lat3", {30'd0, re3}, 32'd0);

    // Requests during INIT must be ignored.
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = 12'd5;
    rst_ni = 1'b1;
    do_init();
    req_i  = 1'b0;

    for (int i = 0; i < 18; i++) begin
      apply(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
            1'b0, vecs[i].exp, vecs[i].eerr);
    end
    drain();
    chk("hold_rdata_lat1", rd1, 32'h1200_5600);
    chk("hold_rdata_lat3", rd3, 32'h1200_5600);

    // Reset lands while a read of addr 1 is still in flight.
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = 12'd1;
    step();
    rst_ni = 1'b0;
    req_i  = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    do_init();
    apply(1'b1, 1'b0, 12'd1, 32'h0, 32'h0, 1'b0, 32'h0000_0000, 2'b00);
    drain();

`ifdef TLUH_SRAM_MEM_PARITY_EN
    apply(1'b1, 1'b1, 12'd2, 32'h0000_00FF, 32'hFFFF_FFFF, 1'b1, 32'h0, 2'b00);
    apply(1'b1, 1'b0, 12'd2, 32'h0, 32'h0, 1'b0, 32'h0000_00FF, 2'b10);
    apply(1'b1, 1'b1, 12'd2, 32'h0000_00FF, 32'hFFFF_FFFF, 1'b0, 32'h0, 2'b00);
    apply(1'b1, 1'b0, 12'd2, 32'h0, 32'h0, 1'b0, 32'h0000_00FF, 2'b00);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tluh_sram_mem.md
Name: tluh_sram_mem

Overview:
- Memory-side consumer that sits directly downstream of tluh_sram_adapter and terminates its req/gnt/we/addr/wdata/wmask interface.
- Returns read data over rvalid/rdata/rerror with a fixed, parameterised latency.
- Holds a register-based word array that is zero-initialised by a hardware init sequencer after every reset.
- Serves as the default backing store behind TL-UH SRAM devices and as the reference memory model for adapter benches.

Parameters:
- SramDw, 32, data width in bits; must be a multiple of 8.
- SramAw, 12, word-address width.
- Depth, 4096, number of words; must satisfy Depth <= 2**SramAw.
- ReadLat, 1, read latency in cycles from accept to rvalid_o; legal range 1..4.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  SramAw  word address.
- wdata_i  in  SramDw  write data.
- wmask_i  in  SramDw  per-bit write enable.
- rdata_o  out  SramDw  read data.
- rvalid_o  out  1  read data valid.
- rerror_o  out  2  [1] uncorrectable, [0] correctable.
- init_done_o  out  1  init sequence complete.

Behaviour:
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, rerror_o=0, init_done_o=0, FSM=INIT, init counter=0, read pipeline cleared.
- FSM INIT:
  - Each cycle writes word[cnt]=0 (and clears its parity when enabled), then cnt++.
  - gnt_o=0 throughout; req_i is ignored.
  - When cnt==Depth-1 is written, go to READY on the next edge. INIT therefore lasts exactly Depth cycles.
- FSM READY:
  - gnt_o=1 combinationally, init_done_o=1. READY is held until reset.
  - Accept = req_i & gnt_o. At most one access per cycle (single port).
- Write accept:
  - word[addr] <= (word & ~wmask_i) | (wdata_i & wmask_i) at the clock edge.
  - No rvalid_o is produced for a write.
- Read accept:
  - Read word[addr] in the accept cycle, then pass it through a ReadLat-deep valid/data pipe.
  - rvalid_o is high for exactly one cycle, ReadLat cycles after the accept.
  - rdata_o holds its last value while rvalid_o=0.
- Read-after-write: a write accepted in cycle N followed by a read of the same address in cycle N+1 returns the new data. No forwarding is needed because the array updates at the edge.
- Back-to-back reads: one rvalid_o per cycle, in order, with no bubbles.
- Address >= Depth:
  - Write: dropped.
  - Read: rvalid_o as normal, rdata_o='1, rerror_o=0.
- Reset asserted mid-operation: in-flight reads are discarded (no rvalid_o), the FSM returns to INIT, and the array is rewritten to zero.
- rerror_o=0 whenever rvalid_o=0.

Optional Feature:
- Macro: TLUH_SRAM_MEM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte, giving a parity array of SramDw/8 bits per word.
  - On a write, parity is recomputed for every byte with any mask bit set, over the merged byte.
  - Input err_inj_i (1 bit) is present. When it is 1 on a write accept, all parity bits of that word are inverted.
  - On a read, rerror_o[1]=1 together with rvalid_o if any byte parity mismatches. rerror_o[0] is always 0.
  - INIT writes zero data with zero parity.
- Undefined: no parity storage, no err_inj_i port, rerror_o tied to 0.

Decomposition:
- tluh_pkg (shared) additions:
  - typedef sram_mem_state_e {INIT, READY}.
  - Constant SramMaxReadLat=4.
  - function byte_parity(data) returning per-byte even parity.
- One sub-module: tluh_sram_rd_pipe, a ReadLat-deep valid/data/error shift pipe with asynchronous clear.
- The array, FSM and parity logic stay in tluh_sram_mem.

Test Plan:
- Reset release with Depth=16 -> gnt_o=0 for exactly 16 cycles, then gnt_o=1 and init_done_o=1; a read of addr 5 returns 0 with rvalid_o ReadLat cycles after accept.
- Full write of 32'h0000_0037 to addr 0, then read addr 0 on the next cycle -> rdata_o=32'h37, rvalid_o a single pulse, no rvalid_o for the write.
- Masked write: addr 3 holds 32'hAABBCCDD, write 32'h11223344 with wmask_i=32'h0000FFFF -> read returns 32'hAABB3344.
- ReadLat=3, reads of addr 1, 2, 3 on consecutive cycles -> three consecutive rvalid_o pulses carrying words 1, 2, 3 in order, each arriving 3 cycles after its accept.
- Read of addr 1 accepted, rst_ni asserted before rvalid_o -> no rvalid_o; INIT reruns and addr 1 reads back 0.
- TLUH_SRAM_MEM_PARITY_EN defined: write addr 2 with err_inj_i=1, then read addr 2 -> rerror_o=2'b10 with rvalid_o; rewrite addr 2 with err_inj_i=0, then read -> rerror_o=2'b00.
